cpu_axi_master_bridge: RTL
==========================

// Module: cpu_axi_master_bridge
// PURPOSE
//  Upstream AXI4 master feeding s00 of the 1x2 interconnect. Converts the custom CPU's two
//  request/ack ports (instruction fetch, data load/store) into single-beat AXI4 transactions.
//  Data port has fixed priority over fetch. One transaction outstanding at a time.
// PARAMETERS
//  DATA_WIDTH  32  CPU and AXI data width (32 only)
//  ADDR_WIDTH  32  address width
//  ID_WIDTH    8   AXI ID width
//  INST_ID     0   arid driven for fetch reads
//  DATA_ID     1   arid/awid driven for data accesses
// PORTS
//  clk             in   1    clock
//  rst             in   1    async active-high reset
//  inst_addr       in   AW   fetch address (PC)
//  inst_req_valid  in   1    fetch request
//  inst_req_ready  out  1    fetch request accepted (1-cycle pulse)
//  inst_rdata      out  DW   fetched instruction
//  inst_rvalid     out  1    inst_rdata valid; held until inst_rready
//  inst_rready     in   1    CPU takes instruction
//  mem_addr        in   AW   load/store address
//  mem_read        in   1    load request
//  mem_write       in   1    store request
//  mem_wdata       in   DW   store data
//  mem_wstrb       in   DW/8 store byte strobes
//  mem_req_ack     out  1    load/store accepted (1-cycle pulse)
//  mem_rdata       out  DW   load data
//  mem_rvalid      out  1    mem_rdata valid; held until mem_rready
//  mem_rready      in   1    CPU takes load data
//  m_axi_aw*/w*/b*/ar*/r*    full AXI4 master set matching s00_axi_*; handshake outs:
//   awvalid, wvalid, bready, arvalid, rready; unused fields: len=0, size=3'b010, burst=INCR,
//   lock/cache/prot/qos/region/user=0, wlast=1
// BEHAVIOUR
//  Reset: state IDLE; all *valid, *ready, *ack outputs 0; held data/addr regs 0.
//  FSM: IDLE -> RD_AR -> RD_R -> RESP -> IDLE (reads); IDLE -> WR_AW_W -> WR_B -> IDLE (stores).
//  IDLE: mem_read|mem_write takes priority; else inst_req_valid. Accept = latch addr/data/strb/
//   source, pulse mem_req_ack or inst_req_ready the same cycle, go next state registered.
//   mem_read&mem_write together is illegal; bench flags it, RTL treats as write.
//  RD_AR: arvalid=1 with latched addr, arid per source; leave on arready.
//  RD_R: rready=1; on rvalid capture rdata into source's rdata reg; rresp ignored.
//  RESP: assert source's rvalid; hold data stable until matching rready, then IDLE.
//   Earliest new accept is the cycle after rready; rready present on rvalid's first cycle is legal.
//  WR_AW_W: awvalid and wvalid raised together; aw_done/w_done flags drop each valid
//   independently on its handshake; both done (same or different cycles) -> WR_B.
//  WR_B: bready=1; on bvalid -> IDLE. bresp ignored; stores have no CPU-visible completion.
//  Latency, zero-wait slave: read accept -> rvalid = 3 cycles (AR, R, RESP).
//   Write accept -> next accept >= 3 cycles.
//  AXI outputs are registered; valids never drop before handshake (AXI rule).
//  Requests arriving while not IDLE are not acked; CPU holds them.
//  Async reset mid-transaction aborts to IDLE immediately. The interconnect shares rst,
//   so no orphan beats are possible.
// STRUCTURE
//  Shared header axi_defs.vh: AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_* constants.
//  FSM state encodings stay as localparams in this file.
//  No sub-module: single FSM plus aw_done/w_done flags and hold regs.
// TESTING (zero-wait AXI RAM model unless noted; random ready stalls in a soak run)
//  fetch 0x1000 (mem=0x00000013) -> arid=0, araddr=0x1000, inst_rvalid 3 cyc later, data 0x13
//  store 0x2004 data 0xDEADBEEF strb 4'b0011 -> awaddr 0x2004, wstrb 0011, one bvalid, back IDLE
//  fetch+load same cycle -> mem_req_ack first, araddr=load addr; fetch acked after load RESP
//  slave awready 4 cycles after wready -> wvalid drops after its handshake, no duplicate W beat
//  inst_rready held low 10 cycles -> inst_rvalid/inst_rdata stable, no new AR issued
//  rst asserted while in RD_R -> all valids 0 async; next fetch proceeds normally

Source files
------------

// File: rtl/cpu_axi_master_bridge_pkg.sv
// Shared AXI field constants and request-source encoding for the CPU-to-AXI
// master bridge. No ports; imported by cpu_axi_master_bridge.
package cpu_axi_master_bridge_pkg;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

   // Which CPU port owns the transaction in flight; selects the ID and the
   // read-data hold register.
   typedef enum logic {
      SRC_INST = 1'b0,
      SRC_DATA = 1'b1
   } req_src_e;

endpackage

// File: rtl/cpu_axi_master_bridge.sv
// CPU to AXI4 master bridge. Turns the CPU fetch port and load/store port into
// single-beat AXI4 transactions, one in flight at a time, data port first.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   inst_*                        fetch request (addr/valid/ready) and response
//                                 (rdata/rvalid/rready)
//   mem_*                         load/store request (addr/read/write/wdata/
//                                 wstrb/req_ack) and load response
//   m_axi_aw*/w*/b*/ar*/r*        AXI4 master channels
//
// state    | meaning
// IDLE     | waiting for a CPU request, acks it combinationally
// RD_AR    | read address presented, waiting for arready
// RD_R     | rready high, waiting for the read beat
// RESP     | read data held to the owning CPU port until its rready
// WR_AW_W  | address and data presented, each drops on its own handshake
// WR_B     | bready high, waiting for the write response
module cpu_axi_master_bridge
   import cpu_axi_master_bridge_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned INST_ID    = 0,
   parameter int unsigned DATA_ID    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   inst_addr,
   input  logic                    inst_req_valid,
   output logic                    inst_req_ready,
   output logic [DATA_WIDTH-1:0]   inst_rdata,
   output logic                    inst_rvalid,
   input  logic                    inst_rready,
   input  logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic                    mem_read,
   input  logic                    mem_write,
   input  logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
   output logic                    mem_req_ack,
   output logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    mem_rvalid,
   input  logic                    mem_rready,
   output logic [ID_WIDTH-1:0]     m_axi_awid,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_awlock,
   output logic [3:0]              m_axi_awcache,
   output logic [2:0]              m_axi_awprot,
   output logic [3:0]              m_axi_awqos,
   output logic [3:0]              m_axi_awregion,
   output logic                    m_axi_awuser,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   output logic                    m_axi_wuser,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [ID_WIDTH-1:0]     m_axi_bid,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_buser,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ID_WIDTH-1:0]     m_axi_arid,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic                    m_axi_arlock,
   output logic [3:0]              m_axi_arcache,
   output logic [2:0]              m_axi_arprot,
   output logic [3:0]              m_axi_arqos,
   output logic [3:0]              m_axi_arregion,
   output logic                    m_axi_aruser,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [ID_WIDTH-1:0]     m_axi_rid,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rlast,
   input  logic                    m_axi_ruser,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_AR   = 3'd1,
      ST_RD_R    = 3'd2,
      ST_RESP    = 3'd3,
      ST_WR_AW_W = 3'd4,
      ST_WR_B    = 3'd5
   } state_e;

   state_e                  state_q, state_d;
   req_src_e                src_q, src_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic [DATA_WIDTH-1:0]   inst_rdata_q, inst_rdata_d;
   logic [DATA_WIDTH-1:0]   mem_rdata_q, mem_rdata_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic                    inst_rvalid_q, inst_rvalid_d;
   logic                    mem_rvalid_q, mem_rvalid_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         src_q         <= SRC_INST;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         inst_rdata_q  <= '0;
         mem_rdata_q   <= '0;
         aw_done_q     <= 1'b0;
         w_done_q      <= 1'b0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         inst_rvalid_q <= 1'b0;
         mem_rvalid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         src_q         <= src_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         inst_rdata_q  <= inst_rdata_d;
         mem_rdata_q   <= mem_rdata_d;
         aw_done_q     <= aw_done_d;
         w_done_q      <= w_done_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         inst_rvalid_q <= inst_rvalid_d;
         mem_rvalid_q  <= mem_rvalid_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      src_d          = src_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      wstrb_d        = wstrb_q;
      inst_rdata_d   = inst_rdata_q;
      mem_rdata_d    = mem_rdata_q;
      aw_done_d      = aw_done_q;
      w_done_d       = w_done_q;
      inst_req_ready = 1'b0;
      mem_req_ack    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Read and write together is treated as a write.
            if (mem_read || mem_write) begin
               mem_req_ack = 1'b1;
               src_d       = SRC_DATA;
               addr_d      = mem_addr;
               if (mem_write) begin
                  wdata_d   = mem_wdata;
                  wstrb_d   = mem_wstrb;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  state_d   = ST_WR_AW_W;
               end else begin
                  state_d = ST_RD_AR;
               end
            end else if (inst_req_valid) begin
               inst_req_ready = 1'b1;
               src_d          = SRC_INST;
               addr_d         = inst_addr;
               state_d        = ST_RD_AR;
            end
         end
         ST_RD_AR: begin
            if (m_axi_arready) state_d = ST_RD_R;
         end
         ST_RD_R: begin
            if (m_axi_rvalid) begin
               if (src_q == SRC_DATA) mem_rdata_d  = m_axi_rdata;
               else                   inst_rdata_d = m_axi_rdata;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if ((src_q == SRC_DATA && mem_rready) || (src_q == SRC_INST && inst_rready))
               state_d = ST_IDLE;
         end
         ST_WR_AW_W: begin
            if (awvalid_q && m_axi_awready) aw_done_d = 1'b1;
            if (wvalid_q && m_axi_wready)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d)      state_d   = ST_WR_B;
         end
         ST_WR_B: begin
            if (m_axi_bvalid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Handshake outputs are registered copies of the next-state decode.
      arvalid_d     = (state_d == ST_RD_AR);
      rready_d      = (state_d == ST_RD_R);
      awvalid_d     = (state_d == ST_WR_AW_W) && !aw_done_d;
      wvalid_d      = (state_d == ST_WR_AW_W) && !w_done_d;
      bready_d      = (state_d == ST_WR_B);
      inst_rvalid_d = (state_d == ST_RESP) && (src_d == SRC_INST);
      mem_rvalid_d  = (state_d == ST_RESP) && (src_d == SRC_DATA);
   end

   assign inst_rdata  = inst_rdata_q;
   assign inst_rvalid = inst_rvalid_q;
   assign mem_rdata   = mem_rdata_q;
   assign mem_rvalid  = mem_rvalid_q;

   assign m_axi_awid     = ID_WIDTH'(DATA_ID);
   assign m_axi_awaddr   = addr_q;
   assign m_axi_awlen    = AXI_LEN_SINGLE;
   assign m_axi_awsize   = AXI_SIZE_4B;
   assign m_axi_awburst  = AXI_BURST_INCR;
   assign m_axi_awlock   = 1'b0;
   assign m_axi_awcache  = 4'd0;
   assign m_axi_awprot   = 3'd0;
   assign m_axi_awqos    = 4'd0;
   assign m_axi_awregion = 4'd0;
   assign m_axi_awuser   = 1'b0;
   assign m_axi_awvalid  = awvalid_q;

   assign m_axi_wdata  = wdata_q;
   assign m_axi_wstrb  = wstrb_q;
   assign m_axi_wlast  = 1'b1;
   assign m_axi_wuser  = 1'b0;
   assign m_axi_wvalid = wvalid_q;

   assign m_axi_bready = bready_q;

   assign m_axi_arid     = (src_q == SRC_DATA) ? ID_WIDTH'(DATA_ID) : ID_WIDTH'(INST_ID);
   assign m_axi_araddr   = addr_q;
   assign m_axi_arlen    = AXI_LEN_SINGLE;
   assign m_axi_arsize   = AXI_SIZE_4B;
   assign m_axi_arburst  = AXI_BURST_INCR;
   assign m_axi_arlock   = 1'b0;
   assign m_axi_arcache  = 4'd0;
   assign m_axi_arprot   = 3'd0;
   assign m_axi_arqos    = 4'd0;
   assign m_axi_arregion = 4'd0;
   assign m_axi_aruser   = 1'b0;
   assign m_axi_arvalid  = arvalid_q;

   assign m_axi_rready = rready_q;

   // Responses are single-beat and errors are not reported to the CPU.
   logic unused_inputs;
   assign unused_inputs = ^{m_axi_bid, m_axi_bresp, m_axi_buser,
                            m_axi_rid, m_axi_rresp, m_axi_rlast, m_axi_ruser};

endmodule
